pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock for all state; rising-edge state update.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: id_rs, id_rt  in  3 each  source register numbers of the instruction in ID; id_uses_rs, id_uses_rt  in  1 each  source actually read.
REQ-004 SHALL have ports: ex_rs, ex_rt  in  3 each  sources of the instruction in EX.
REQ-005 SHALL have ports: ex_rd, mem_rd, wb_rd  in  3 each; ex_RegWrite, mem_RegWrite, wb_RegWrite  in  1 each; ex_MemRead  in  1  EX instruction is a load.
REQ-006 SHALL have ports: branch_taken  in  1  branch resolved taken in EX; mem_busy  in  1  data memory not ready this cycle.
REQ-007 SHALL have ports: pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage enables (1 = load).
REQ-008 SHALL have ports: if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  force stage register to NOP / RegWrite=0.
REQ-009 SHALL have ports: fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
REQ-010 SHALL have ports: state  out  2  registered controller state; stall_count  out  16  saturating stall-cycle counter.

Function
REQ-011 Register 0 SHALL never be a hazard or forwarding source (any rd == 0 ignored).
REQ-012 All control outputs except state and stall_count SHALL be combinational from current inputs, acting at the next rising edge (zero-cycle latency).
REQ-013 Priority each cycle SHALL be: mem_busy > branch_taken > data hazard > none.
REQ-014 mem_busy=1: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_bubble = 1; no flushes.
REQ-015 branch_taken=1 (mem_busy=0): if_id_flush = 1, id_ex_flush = 1, all write enables = 1.
REQ-016 Data hazard (no higher event): pc_write = 0, if_id_write = 0, id_ex_flush = 1; other enables = 1.
REQ-017 No event: all write enables 1, all flush/bubble outputs 0.
REQ-018 state SHALL encode RUN=00, STALL=01, FLUSH=10, MWAIT=11 and SHALL load, every rising edge, the highest-priority event of that cycle (none -> RUN).
REQ-019 stall_count SHALL increment by 1 on every rising edge where REQ-014 or REQ-016 applies, saturating at 16'hFFFF (no wrap).
REQ-020 Register writes in WB SHALL be assumed visible to ID the same cycle (write-before-read); a WB writer never causes a hazard.
REQ-021 Simultaneous hazard on rs and rt SHALL produce a single stall, not two.

Reset
REQ-022 rst_n=0 SHALL immediately force state=RUN and stall_count=0, regardless of clk.
REQ-023 Combinational outputs SHALL follow REQ-013..017 during reset; reset asserted mid-stall SHALL clear state on assertion and resume in RUN after deassertion.

Configuration
REQ-024 Macro FORWARDING_EN defined: fwd_a/fwd_b from EX/MEM match (mem_RegWrite, mem_rd==ex_rs/ex_rt) with priority over MEM/WB match (wb_RegWrite, wb_rd); data hazard = ex_MemRead & ex_RegWrite & ex_rd matches a used ID source (load-use, one bubble).
REQ-025 Macro FORWARDING_EN undefined: fwd_a = fwd_b = 00 always; data hazard = used ID source matches ex_rd (ex_RegWrite) or mem_rd (mem_RegWrite), stall held until no match.

Verification
REQ-026 FORWARDING_EN, ex_MemRead=1, ex_RegWrite=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_flush=1; next edge state=01, stall_count=1.
REQ-027 FORWARDING_EN, mem_rd=2 and wb_rd=2 both writing, ex_rs=2 -> fwd_a=10; mem_RegWrite=0 -> fwd_a=01; ex_rs=0 with rd=0 -> fwd_a=00.
REQ-028 branch_taken=1 and load-use hazard same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; next state=10, stall_count unchanged.
REQ-029 mem_busy=1 for 3 cycles with branch_taken=1 -> all enables 0, mem_wb_bubble=1, no flush; state=11, stall_count +3.
REQ-030 stall_count preset near saturation (65534) plus 3 stall cycles -> holds 16'hFFFF; rst_n low between edges -> 0 and state=00 without a clock edge.
REQ-031 FORWARDING_EN undefined, mem_rd=5 mem_RegWrite=1, id_rt=5 id_uses_rt=1 -> stall; wb_rd=5 only -> no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and its hazard controller.
// The datapath side uses the master modport and the controller uses the slave modport.
interface pipeline_hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [2:0]  ex_rs;
    logic [2:0]  ex_rt;
    logic [2:0]  ex_rd;
    logic [2:0]  mem_rd;
    logic [2:0]  wb_rd;
    logic        ex_RegWrite;
    logic        mem_RegWrite;
    logic        wb_RegWrite;
    logic        ex_MemRead;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_bubble;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               ex_rd, mem_rd, wb_rd, ex_RegWrite, mem_RegWrite, wb_RegWrite,
               ex_MemRead, branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b,
               state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt,
               ex_rd, mem_rd, wb_rd, ex_RegWrite, mem_RegWrite, wb_RegWrite,
               ex_MemRead, branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
               if_id_flush, id_ex_flush, mem_wb_bubble, fwd_a, fwd_b,
               state, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: stage enables, flushes, operand forwarding and a saturating stall counter.
// Define FORWARDING_EN for EX/MEM + MEM/WB forwarding with load-use stalls; undefined means stall on any RAW match.
module pipeline_hazard_ctrl (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_hazard_ctrl_if.slave        hz
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        MWAIT = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        hazard;

    // A register is read in ID only if its source is used; r0 is never a real dependency.
    function automatic logic id_reads(input logic [2:0] r, input logic [2:0] rs, input logic [2:0] rt,
                                      input logic use_rs, input logic use_rt);
        return (r != 3'd0) && ((use_rs && rs == r) || (use_rt && rt == r));
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [2:0] src, input logic mem_we, input logic [2:0] mem_rd,
                                           input logic wb_we, input logic [2:0] wb_rd);
        if (mem_we && mem_rd != 3'd0 && mem_rd == src)
            return 2'b10;
        else if (wb_we && wb_rd != 3'd0 && wb_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign hazard = hz.ex_MemRead && hz.ex_RegWrite &&
                    id_reads(hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt);
    assign hz.fwd_a = fwd_sel(hz.ex_rs, hz.mem_RegWrite, hz.mem_rd, hz.wb_RegWrite, hz.wb_rd);
    assign hz.fwd_b = fwd_sel(hz.ex_rt, hz.mem_RegWrite, hz.mem_rd, hz.wb_RegWrite, hz.wb_rd);
`else
    // WB results are written before ID reads them, so only EX and MEM writers can conflict.
    assign hazard = (hz.ex_RegWrite  && id_reads(hz.ex_rd,  hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt)) ||
                    (hz.mem_RegWrite && id_reads(hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_uses_rs, hz.id_uses_rt));
    assign hz.fwd_a = 2'b00;
    assign hz.fwd_b = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.ex_rs, hz.ex_rt, hz.wb_rd, hz.wb_RegWrite};
`endif

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d          = RUN;
        hz.pc_write      = 1'b1;
        hz.if_id_write   = 1'b1;
        hz.id_ex_write   = 1'b1;
        hz.ex_mem_write  = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.mem_wb_bubble = 1'b0;

        if (hz.mem_busy)          state_d = MWAIT;
        else if (hz.branch_taken) state_d = FLUSH;
        else if (hazard)          state_d = STALL;

        case (state_d)
            MWAIT: begin
                hz.pc_write      = 1'b0;
                hz.if_id_write   = 1'b0;
                hz.id_ex_write   = 1'b0;
                hz.ex_mem_write  = 1'b0;
                hz.mem_wb_bubble = 1'b1;
            end
            FLUSH: begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end
            STALL: begin
                hz.pc_write    = 1'b0;
                hz.if_id_write = 1'b0;
                hz.id_ex_flush = 1'b1;
            end
            default: ;
        endcase

        stall_count_d = stall_count_q;
        if ((state_d == STALL || state_d == MWAIT) && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.state       = state_q;
    assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a rule-level model checked every negedge plus directed literal checks.
// Builds with or without FORWARDING_EN; expectations follow the same macro.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pipeline_hazard_ctrl_if hz_if ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Events by priority: 3 = memory wait, 2 = branch flush, 1 = data stall, 0 = none.
    function automatic bit src_read(input int r);
        if (r == 0) return 0;
        return (hz_if.id_uses_rs && int'(hz_if.id_rs) == r) || (hz_if.id_uses_rt && int'(hz_if.id_rt) == r);
    endfunction

    function automatic int model_event();
        bit stall;
`ifdef FORWARDING_EN
        stall = hz_if.ex_MemRead && hz_if.ex_RegWrite && src_read(int'(hz_if.ex_rd));
`else
        stall = (hz_if.ex_RegWrite && src_read(int'(hz_if.ex_rd))) ||
                (hz_if.mem_RegWrite && src_read(int'(hz_if.mem_rd)));
`endif
        if (hz_if.mem_busy) return 3;
        if (hz_if.branch_taken) return 2;
        if (stall) return 1;
        return 0;
    endfunction

    function automatic int model_fwd(input int src);
`ifdef FORWARDING_EN
        if (src != 0 && hz_if.mem_RegWrite && int'(hz_if.mem_rd) == src) return 2;
        if (src != 0 && hz_if.wb_RegWrite && int'(hz_if.wb_rd) == src) return 1;
`endif
        return 0;
    endfunction

    int m_state = 0;
    int m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_count <= 0;
        end else begin
            m_state <= model_event();
            if (model_event() == 1 || model_event() == 3)
                m_count <= (m_count >= 65535) ? 65535 : m_count + 1;
        end
    end

    always @(negedge clk) begin : compare
        int ev;
        ev = model_event();
        check("pc_write",      16'(hz_if.pc_write),      16'(ev == 0 || ev == 2));
        check("if_id_write",   16'(hz_if.if_id_write),   16'(ev == 0 || ev == 2));
        check("id_ex_write",   16'(hz_if.id_ex_write),   16'(ev != 3));
        check("ex_mem_write",  16'(hz_if.ex_mem_write),  16'(ev != 3));
        check("if_id_flush",   16'(hz_if.if_id_flush),   16'(ev == 2));
        check("id_ex_flush",   16'(hz_if.id_ex_flush),   16'(ev == 1 || ev == 2));
        check("mem_wb_bubble", 16'(hz_if.mem_wb_bubble), 16'(ev == 3));
        check("fwd_a",         16'(hz_if.fwd_a),         16'(model_fwd(int'(hz_if.ex_rs))));
        check("fwd_b",         16'(hz_if.fwd_b),         16'(model_fwd(int'(hz_if.ex_rt))));
        check("state",         16'(hz_if.state),         16'(m_state));
        check("stall_count",   hz_if.stall_count,        16'(m_count));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        hz_if.id_rs = 0; hz_if.id_rt = 0; hz_if.id_uses_rs = 0; hz_if.id_uses_rt = 0;
        hz_if.ex_rs = 0; hz_if.ex_rt = 0; hz_if.ex_rd = 0; hz_if.mem_rd = 0; hz_if.wb_rd = 0;
        hz_if.ex_RegWrite = 0; hz_if.mem_RegWrite = 0; hz_if.wb_RegWrite = 0;
        hz_if.ex_MemRead = 0; hz_if.branch_taken = 0; hz_if.mem_busy = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [2:0] rd);
        hz_if.ex_MemRead = 1; hz_if.ex_RegWrite = 1; hz_if.ex_rd = rd;
        hz_if.id_rs = rd; hz_if.id_uses_rs = 1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check("reset state",       16'(hz_if.state), 16'h0);
        check("reset stall_count", hz_if.stall_count, 16'h0);
        check("reset pc_write",    16'(hz_if.pc_write), 16'h1);
        #10 rst_n = 1'b1;
        edge_step();

        // load-use on r3
        load_use(3'd3);
        #1;
        check("lu pc_write",    16'(hz_if.pc_write), 16'h0);
        check("lu if_id_write", 16'(hz_if.if_id_write), 16'h0);
        check("lu id_ex_flush", 16'(hz_if.id_ex_flush), 16'h1);
        edge_step();
        check("lu state", 16'(hz_if.state), 16'h1);
        check("lu count", hz_if.stall_count, 16'd1);

        // rs and rt both hazard: one stall only
        hz_if.id_rt = 3'd3; hz_if.id_uses_rt = 1;
        edge_step();
        check("dual count", hz_if.stall_count, 16'd2);

        // branch beats load-use
        hz_if.branch_taken = 1;
        #1;
        check("br if_id_flush", 16'(hz_if.if_id_flush), 16'h1);
        check("br id_ex_flush", 16'(hz_if.id_ex_flush), 16'h1);
        check("br pc_write",    16'(hz_if.pc_write), 16'h1);
        edge_step();
        check("br state", 16'(hz_if.state), 16'h2);
        check("br count", hz_if.stall_count, 16'd2);

        // memory busy beats branch for three cycles
        hz_if.mem_busy = 1;
        #1;
        check("mw ex_mem_write",  16'(hz_if.ex_mem_write), 16'h0);
        check("mw id_ex_write",   16'(hz_if.id_ex_write), 16'h0);
        check("mw mem_wb_bubble", 16'(hz_if.mem_wb_bubble), 16'h1);
        check("mw if_id_flush",   16'(hz_if.if_id_flush), 16'h0);
        repeat (3) edge_step();
        check("mw state", 16'(hz_if.state), 16'h3);
        check("mw count", hz_if.stall_count, 16'd5);

        idle();
        edge_step();
        check("run state", 16'(hz_if.state), 16'h0);
        check("run count", hz_if.stall_count, 16'd5);

        // forwarding select
        hz_if.mem_rd = 3'd2; hz_if.wb_rd = 3'd2; hz_if.mem_RegWrite = 1; hz_if.wb_RegWrite = 1;
        hz_if.ex_rs = 3'd2; hz_if.ex_rt = 3'd4;
        #1;
`ifdef FORWARDING_EN
        check("fwd mem", 16'(hz_if.fwd_a), 16'h2);
`else
        check("fwd mem", 16'(hz_if.fwd_a), 16'h0);
`endif
        check("fwd_b none", 16'(hz_if.fwd_b), 16'h0);
        hz_if.mem_RegWrite = 0;
        #1;
`ifdef FORWARDING_EN
        check("fwd wb", 16'(hz_if.fwd_a), 16'h1);
`else
        check("fwd wb", 16'(hz_if.fwd_a), 16'h0);
`endif
        hz_if.mem_RegWrite = 1; hz_if.mem_rd = 0; hz_if.wb_rd = 0; hz_if.ex_rs = 0;
        #1;
        check("fwd r0", 16'(hz_if.fwd_a), 16'h0);
        edge_step();

        // MEM writer vs WB writer for an ID source
        idle();
        hz_if.mem_rd = 3'd5; hz_if.mem_RegWrite = 1; hz_if.id_rt = 3'd5; hz_if.id_uses_rt = 1;
        #1;
`ifdef FORWARDING_EN
        check("mem raw pc_write", 16'(hz_if.pc_write), 16'h1);
`else
        check("mem raw pc_write", 16'(hz_if.pc_write), 16'h0);
`endif
        edge_step();
        hz_if.mem_RegWrite = 0; hz_if.mem_rd = 0; hz_if.wb_rd = 3'd5; hz_if.wb_RegWrite = 1;
        #1;
        check("wb raw pc_write", 16'(hz_if.pc_write), 16'h1);
        edge_step();

        // r0 load never stalls
        idle();
        load_use(3'd0);
        #1;
        check("r0 pc_write", 16'(hz_if.pc_write), 16'h1);
        edge_step();

        // saturation from a fresh count
        idle();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        hz_if.mem_busy = 1;
        repeat (65534) edge_step();
        check("sat pre", hz_if.stall_count, 16'd65534);
        repeat (3) edge_step();
        check("sat hold", hz_if.stall_count, 16'hFFFF);

        // async reset mid-stall, between edges
        rst_n = 1'b0;
        #1;
        check("areset state", 16'(hz_if.state), 16'h0);
        check("areset count", hz_if.stall_count, 16'h0);
        check("areset comb pc_write", 16'(hz_if.pc_write), 16'h0);
        #1 rst_n = 1'b1;
        idle();
        edge_step();
        check("resume state", 16'(hz_if.state), 16'h0);
        check("resume count", hz_if.stall_count, 16'h0);
        edge_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
